csr_trap_sequencer: RTL and testbench

Sequencer and port arbiter for the 4-entry machine CSR file (mstatus, mtvec, mepc, mcause). The CSR file has one combinational read port and one write port. This block shares both ports between the normal pipeline (the IDU reads, the WBU writes) and its own multi-cycle trap-entry (ecall) and trap-return (mret) sequences. It also produces the PC redirect that ends each sequence. It sits between the WBU commit stage and the CSR file, and stalls the pipeline while a sequence runs.

---
 rtl/csr_trap_sequencer.sv | 163 ++++++++++++++++
 tb/tb_csr_trap_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_sequencer.sv
// Shares the machine CSR file ports between the pipeline and the ecall/mret sequences,
// and issues the redirect that ends each sequence. Define MSTATUS_UPDATE_EN to enable mstatus updates.
module csr_trap_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret_valid,
  input  logic        wb_csr_wr,
  input  logic [1:0]  wb_csr_rd,
  input  logic [31:0] wb_csr_data,
  input  logic [1:0]  idu_csr_rs,
  output logic        csr_wr,
  output logic [1:0]  csr_rd,
  output logic [31:0] csr_busW,
  output logic [1:0]  csr_rs,
  input  logic [31:0] csr_rs_data,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [1:0] CSR_MSTATUS = 2'd0;
  localparam logic [1:0] CSR_MTVEC   = 2'd1;
  localparam logic [1:0] CSR_MEPC    = 2'd2;
  localparam logic [1:0] CSR_MCAUSE  = 2'd3;
  localparam logic [31:0] VEC_MASK   = ~32'h3;

  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_STATUS, M_STATUS, M_EPC, REDIR
  } state_t;

  state_t      state;
  logic [31:0] pc_lat;
  logic [31:0] cause_lat;
  logic [31:0] mtvec_lat;
  logic [31:0] target;

`ifdef MSTATUS_UPDATE_EN
  logic [31:0] mstatus_lat;

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M-mode.
  function automatic logic [31:0] trap_status(input logic [31:0] s);
    logic [31:0] r;
    r       = s;
    r[7]    = s[3];
    r[3]    = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Trap return: MIE <- MPIE, MPIE <- 1, MPP <- M-mode.
  function automatic logic [31:0] mret_status(input logic [31:0] s);
    logic [31:0] r;
    r       = s;
    r[3]    = s[7];
    r[7]    = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc_lat    <= '0;
      cause_lat <= '0;
      mtvec_lat <= '0;
      target    <= '0;
`ifdef MSTATUS_UPDATE_EN
      mstatus_lat <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (trap_valid) begin
            state     <= T_EPC;
            pc_lat    <= trap_pc;
            cause_lat <= trap_cause;
          end else if (mret_valid) begin
`ifdef MSTATUS_UPDATE_EN
            state <= M_STATUS;
`else
            state <= M_EPC;
`endif
          end
        end
        T_EPC: begin
          mtvec_lat <= csr_rs_data;
          state     <= T_CAUSE;
        end
`ifdef MSTATUS_UPDATE_EN
        T_CAUSE: begin
          mstatus_lat <= csr_rs_data;
          state       <= T_STATUS;
        end
        T_STATUS: begin
          target <= mtvec_lat & VEC_MASK;
          state  <= REDIR;
        end
        M_STATUS: state <= M_EPC;
`else
        T_CAUSE: begin
          target <= mtvec_lat & VEC_MASK;
          state  <= REDIR;
        end
`endif
        M_EPC: begin
          target <= csr_rs_data;
          state  <= REDIR;
        end
        REDIR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Port mux: pass-through in IDLE, sequence-owned otherwise.
  always_comb begin
    csr_wr   = 1'b0;
    csr_rd   = wb_csr_rd;
    csr_busW = wb_csr_data;
    csr_rs   = idu_csr_rs;
    case (state)
      IDLE: csr_wr = wb_csr_wr;
      T_EPC: begin
        csr_wr   = 1'b1;
        csr_rd   = CSR_MEPC;
        csr_busW = pc_lat;
        csr_rs   = CSR_MTVEC;
      end
      T_CAUSE: begin
        csr_wr   = 1'b1;
        csr_rd   = CSR_MCAUSE;
        csr_busW = cause_lat;
        csr_rs   = CSR_MSTATUS;
      end
`ifdef MSTATUS_UPDATE_EN
      T_STATUS: begin
        csr_wr   = 1'b1;
        csr_rd   = CSR_MSTATUS;
        csr_busW = trap_status(mstatus_lat);
        csr_rs   = CSR_MSTATUS;
      end
      M_STATUS: begin
        csr_wr   = 1'b1;
        csr_rd   = CSR_MSTATUS;
        csr_busW = mret_status(csr_rs_data);
        csr_rs   = CSR_MSTATUS;
      end
`endif
      M_EPC: csr_rs = CSR_MEPC;
      default: ;
    endcase
    if (rst) csr_wr = 1'b0;
  end

  assign busy           = (state != IDLE) | trap_valid | mret_valid;
  assign redirect_valid = (state == REDIR);
  assign redirect_pc    = target;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Bench for csr_trap_sequencer: CSR file model, directed scenarios and randomized trap/mret sequences.
module tb_csr_trap_sequencer;

`ifdef MSTATUS_UPDATE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk, rst;
  logic        trap_valid, mret_valid, wb_csr_wr;
  logic [31:0] trap_pc, trap_cause, wb_csr_data;
  logic [1:0]  wb_csr_rd, idu_csr_rs;
  logic        csr_wr, busy, redirect_valid;
  logic [1:0]  csr_rd, csr_rs;
  logic [31:0] csr_busW, csr_rs_data, redirect_pc;

  int checks = 0;
  int failures = 0;

  csr_trap_sequencer dut (
    .clk(clk), .rst(rst), .trap_valid(trap_valid), .trap_pc(trap_pc),
    .trap_cause(trap_cause), .mret_valid(mret_valid), .wb_csr_wr(wb_csr_wr),
    .wb_csr_rd(wb_csr_rd), .wb_csr_data(wb_csr_data), .idu_csr_rs(idu_csr_rs),
    .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_busW(csr_busW), .csr_rs(csr_rs),
    .csr_rs_data(csr_rs_data), .busy(busy), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file: 0 mstatus, 1 mtvec, 2 mepc, 3 mcause
  logic [31:0] csr [4] = '{default: 32'h0};
  always @(posedge clk) if (csr_wr) csr[csr_rd] <= csr_busW;
  assign csr_rs_data = csr[csr_rs];

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_trap_status(input logic [31:0] s);
    logic [31:0] mpie, mie;
    mpie = (s >> 3) & 32'h1;
    mie  = 32'h0;
    return (s & ~32'h1888) | (mpie << 7) | (mie << 3) | 32'h1800;
  endfunction

  function automatic logic [31:0] ref_mret_status(input logic [31:0] s);
    logic [31:0] mpie;
    mpie = (s >> 7) & 32'h1;
    return (s & ~32'h1888) | (mpie << 3) | 32'h80 | 32'h1800;
  endfunction

  // Called at posedge+1; writes one CSR through the IDLE pass-through.
  task automatic wb_write(input logic [1:0] idx, input logic [31:0] d);
    wb_csr_wr = 1'b1; wb_csr_rd = idx; wb_csr_data = d;
    @(posedge clk); #1;
    wb_csr_wr = 1'b0;
  endtask

  // Pulses trap or mret for one cycle (cycle 0), then observes 8 cycles.
  task automatic run_seq(input bit is_trap, input bit wbw, input logic [1:0] wbrd,
                         input logic [31:0] wbd, input bit both,
                         output int rcyc, output int nred, output int nbusy,
                         output logic [31:0] rpc);
    rcyc = -1; nred = 0; nbusy = 0; rpc = '0;
    trap_valid = is_trap; mret_valid = !is_trap || both;
    wb_csr_wr = wbw; wb_csr_rd = wbrd; wb_csr_data = wbd;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (redirect_valid) begin
        nred++;
        if (rcyc < 0) rcyc = c;
        rpc = redirect_pc;
      end
      @(posedge clk); #1;
      trap_valid = 1'b0; mret_valid = 1'b0; wb_csr_wr = 1'b0;
    end
  endtask

  int rcyc, nred, nbusy;
  logic [31:0] rpc;
  logic [31:0] m_pc, m_cause, m_tvec, m_status, m_epc, exp_status;
  bit do_trap;

  initial begin
    rst = 1'b1; trap_valid = 0; mret_valid = 0; trap_pc = 0; trap_cause = 0;
    wb_csr_wr = 1'b1; wb_csr_rd = 2'd1; wb_csr_data = 32'hdeadbeef; idu_csr_rs = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_csr_wr_forced_low", {31'b0, csr_wr}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("reset_redirect_pc", redirect_pc, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; wb_csr_wr = 1'b0;
    chk("reset_no_write_landed", csr[1], 32'h0);

    idu_csr_rs = 2'd2;
    @(negedge clk);
    chk("idle_read_passthrough", {30'b0, csr_rs}, 32'h2);
    @(posedge clk); #1;

    // Directed trap
    wb_write(2'd1, 32'h80000100);
    wb_write(2'd0, 32'h00001808);
    chk("idle_write_passthrough", csr[1], 32'h80000100);
    trap_pc = 32'h80000040; trap_cause = 32'hb;
    run_seq(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, rcyc, nred, nbusy, rpc);
    chk("trap_mepc", csr[2], 32'h80000040);
    chk("trap_mcause", csr[3], 32'hb);
    chk("trap_mstatus", csr[0], EN ? 32'h1880 : 32'h1808);
    chk("trap_redirect_pc", rpc, 32'h80000100);
    chk("trap_redirect_cycle", rcyc, EN ? 4 : 3);
    chk("trap_redirect_count", nred, 1);
    chk("trap_busy_cycles", nbusy, EN ? 5 : 4);

    // Directed mret
    wb_write(2'd2, 32'h80000044);
    wb_write(2'd0, 32'h00001880);
    run_seq(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, rcyc, nred, nbusy, rpc);
    chk("mret_mstatus", csr[0], EN ? 32'h1888 : 32'h1880);
    chk("mret_redirect_pc", rpc, 32'h80000044);
    chk("mret_redirect_cycle", rcyc, EN ? 3 : 2);
    chk("mret_redirect_count", nred, 1);
    chk("mret_busy_cycles", nbusy, EN ? 4 : 3);

    // Low bits of mtvec masked
    wb_write(2'd1, 32'h80000103);
    run_seq(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, rcyc, nred, nbusy, rpc);
    chk("mtvec_mask_redirect_pc", rpc, 32'h80000100);

    // trap + mret + pipeline mtvec write in one cycle
    trap_pc = 32'h80000120;
    run_seq(1'b1, 1'b1, 2'd1, 32'h80000200, 1'b1, rcyc, nred, nbusy, rpc);
    chk("collide_mtvec_written", csr[1], 32'h80000200);
    chk("collide_trap_wins_mepc", csr[2], 32'h80000120);
    chk("collide_redirect_pc", rpc, 32'h80000200);
    chk("collide_redirect_cycle", rcyc, EN ? 4 : 3);

    // Reset during T_CAUSE
    wb_write(2'd3, 32'h00000055);
    trap_pc = 32'h80000300; trap_cause = 32'hb;
    trap_valid = 1'b1;
    @(posedge clk); #1; trap_valid = 1'b0;   // cycle 1: T_EPC
    @(posedge clk); #1; rst = 1'b1;          // cycle 2: T_CAUSE
    @(negedge clk);
    chk("midreset_csr_wr_low", {31'b0, csr_wr}, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    nred = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) chk("midreset_idle_busy", {31'b0, busy}, 32'h0);
      if (redirect_valid) nred++;
      @(posedge clk); #1;
    end
    chk("midreset_no_redirect", nred, 0);
    chk("midreset_mepc_written", csr[2], 32'h80000300);
    chk("midreset_mcause_kept", csr[3], 32'h55);

    // Randomized sequences against the reference model
    for (int i = 0; i < 24; i++) begin
      do_trap  = $urandom_range(0, 1) == 1;
      m_status = $urandom;
      wb_write(2'd0, m_status);
      if (do_trap) begin
        m_tvec = $urandom; m_pc = $urandom; m_cause = $urandom;
        wb_write(2'd1, m_tvec);
        trap_pc = m_pc; trap_cause = m_cause;
        run_seq(1'b1, 1'b0, 2'd0, 32'h0, $urandom_range(0, 1) == 1, rcyc, nred, nbusy, rpc);
        exp_status = EN ? ref_trap_status(m_status) : m_status;
        chk($sformatf("rnd%0d_trap_mepc", i), csr[2], m_pc);
        chk($sformatf("rnd%0d_trap_mcause", i), csr[3], m_cause);
        chk($sformatf("rnd%0d_trap_mstatus", i), csr[0], exp_status);
        chk($sformatf("rnd%0d_trap_rpc", i), rpc, m_tvec & ~32'h3);
        chk($sformatf("rnd%0d_trap_rcyc", i), rcyc, EN ? 4 : 3);
        chk($sformatf("rnd%0d_trap_busy", i), nbusy, EN ? 5 : 4);
      end else begin
        m_epc = $urandom;
        wb_write(2'd2, m_epc);
        run_seq(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, rcyc, nred, nbusy, rpc);
        exp_status = EN ? ref_mret_status(m_status) : m_status;
        chk($sformatf("rnd%0d_mret_mstatus", i), csr[0], exp_status);
        chk($sformatf("rnd%0d_mret_rpc", i), rpc, m_epc);
        chk($sformatf("rnd%0d_mret_rcyc", i), rcyc, EN ? 3 : 2);
        chk($sformatf("rnd%0d_mret_busy", i), nbusy, EN ? 4 : 3);
      end
      chk($sformatf("rnd%0d_redirect_count", i), nred, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
